// File: rtl/sobol_seq_gen_pkg.sv
// Shared widths, state encoding and reset defaults for the Sobol sequence generator.
package sobol_seq_gen_pkg;

  localparam int BITWIDTH    = 4;
  localparam int LOGBITWIDTH = 2;

  typedef logic [BITWIDTH-1:0]    word_t;
  typedef logic [LOGBITWIDTH-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // First-dimension (van der Corput) direction vector for index i.
  function automatic word_t defaultVector(input int i);
    return word_t'(1) << (BITWIDTH - 1 - i);
  endfunction

endpackage

// File: rtl/sobol_seq_gen_if.sv
// Control, direction-vector load and sample-stream signals of the Sobol generator.
interface sobol_seq_gen_if;
  import sobol_seq_gen_pkg::*;

  logic  start;
  logic  stop;
  logic  dv_we;
  idx_t  dv_addr;
  word_t dv_data;
  logic  out_ready;
  logic  out_valid;
  word_t sobol_out;
  logic  seq_wrap;
  logic  busy;

  // The generator itself: consumes control and load strobes, sources the sample stream.
  modport master (
    input  start, stop, dv_we, dv_addr, dv_data, out_ready,
    output out_valid, sobol_out, seq_wrap, busy
  );

  // The controller/consumer side.
  modport slave (
    output start, stop, dv_we, dv_addr, dv_data, out_ready,
    input  out_valid, sobol_out, seq_wrap, busy
  );

endinterface

// File: rtl/sobol_seq_gen_lsz.sv
// Least-significant-zero finder: locates the bit that flips between successive Gray codes.
module sobol_seq_gen_lsz
  import sobol_seq_gen_pkg::*;
(
  input  word_t iGray,
  output idx_t  lszIdx,
  output word_t lszOneHot
);

  // Isolate the lowest zero bit as a one-hot word (all zeros when iGray is all ones).
  assign lszOneHot = ~iGray & (iGray + word_t'(1));

  // Scan from the top so the lowest zero seen last wins; all-ones input yields index 0.
  always_comb begin
    lszIdx = '0;
    for (int i = BITWIDTH - 1; i >= 0; i--) begin
      if (!iGray[i]) begin
        lszIdx = idx_t'(i);
      end
    end
  end

endmodule

// File: rtl/sobol_seq_gen.sv
// Sobol sequence generator: Gray-code XOR update over a loadable direction-vector table,
// streamed out through a valid/ready handshake.
module sobol_seq_gen
  import sobol_seq_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  sobol_seq_gen_if.master  bus
);

  state_e state_q, state_d;
  word_t  cnt_q, cnt_d;
  word_t  sobol_q, sobol_d;
  logic   wrap_q, wrap_d;
  word_t  vec_q [BITWIDTH];

  idx_t   lszIdx;
  word_t  lszOneHotUnused;
  logic   xfer;
  logic   cntFull;
  logic   dvWrite;

  sobol_seq_gen_lsz u_lsz (
    .iGray     (cnt_q),
    .lszIdx    (lszIdx),
    .lszOneHot (lszOneHotUnused)
  );

  assign xfer    = (state_q == RUN) && bus.out_ready;
  assign cntFull = &cnt_q;
  assign dvWrite = (state_q == IDLE) && bus.dv_we && (int'(bus.dv_addr) < BITWIDTH);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start only matters in IDLE, stop only in RUN, so start wins when both arrive in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (bus.stop)  state_d = IDLE;
    endcase
  end

  // FSM outputs plus the registered sample and wrap pulse.
  always_comb begin
    bus.out_valid = (state_q == RUN);
    bus.busy      = (state_q == RUN);
    bus.sobol_out = sobol_q;
    bus.seq_wrap  = wrap_q;
  end

  // Sample datapath next state: stop clears and overrides any concurrent transfer.
  always_comb begin
    cnt_d   = cnt_q;
    sobol_d = sobol_q;
    wrap_d  = 1'b0;
    if ((state_q == RUN) && bus.stop) begin
      cnt_d   = '0;
      sobol_d = '0;
    end else if (xfer) begin
      if (cntFull) begin
        cnt_d   = '0;
        sobol_d = '0;
        wrap_d  = 1'b1;
      end else begin
        cnt_d   = cnt_q + word_t'(1);
        sobol_d = sobol_q ^ vec_q[lszIdx];
      end
    end
  end

  // Sample datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sobol_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sobol_q <= sobol_d;
      wrap_q  <= wrap_d;
    end
  end

  // Direction-vector table: reset to van der Corput, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BITWIDTH; i++) begin
        vec_q[i] <= defaultVector(i);
      end
    end else if (dvWrite) begin
      vec_q[bus.dv_addr] <= bus.dv_data;
    end
  end

endmodule
